npc_exec_ctrl: RTL and testbench
================================

Name: npc_exec_ctrl

Overview:
Multi-cycle sequencer for the single-issue NPC core. It fetches an instruction over a valid/ready instruction-memory port and latches it for the combinational instruction decoder. It then steps the instruction through DECODE/EXEC/WB and gates the register-file write strobe from the decoder's write-enable. It advances the PC, counts retired instructions and halts sticky on ebreak.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset.
TIMEOUT_CYCLES, 1024, fetch watchdog limit (used only with NPC_FETCH_TIMEOUT_EN).

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level; leaves IDLE when 1
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  32  fetch address, equals pc
imem_rsp_valid  input  1  fetch data valid
imem_rsp_data  input  32  fetched instruction
inst  output  32  latched instruction, drives decoder
dec_isbreak  input  1  decoder: inst is ebreak
dec_reg_wen  input  1  decoder: inst writes rd
rf_wen  output  1  register-file write strobe
pc  output  32  current PC
retired  output  32  retired-instruction count
state  output  3  FSM state encoding
halt  output  1  core halted, sticky
err  output  1  fetch timeout flag

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, pc=RESET_PC, inst=0, retired=0, all 1-bit outputs 0. Reset mid-operation abandons the in-flight fetch; late responses are ignored.
- Encoding: IDLE=0, FETCH=1, WAIT=2, DECODE=3, EXEC=4, WB=5, HALT=6. Value 7 is unreachable; if reached, it goes to HALT.
- IDLE: if start, go to FETCH.
- FETCH: imem_req_valid=1, imem_addr=pc, held stable until imem_req_ready.
  - ready & !rsp_valid: go to WAIT.
  - ready & rsp_valid (same-cycle response): latch inst, go to DECODE.
  - !ready: stay in FETCH.
- WAIT: imem_req_valid=0. On imem_rsp_valid, latch inst<=imem_rsp_data and go to DECODE.
- Responses in any state other than FETCH-with-ready or WAIT are ignored.
- DECODE: one cycle; decoder inputs are sampled from the registered inst.
  - dec_isbreak: retired+=1, go to HALT. pc is not advanced.
  - otherwise: go to EXEC.
- EXEC: one cycle, go to WB.
- WB: rf_wen=dec_reg_wen for exactly this cycle. pc<=pc+4 (mod 2^32, wraps 32'hFFFFFFFC to 0). retired+=1 (wraps at 2^32). Go to FETCH.
- Undecodable instructions (dec_reg_wen=0, dec_isbreak=0) retire as NOPs: no write, pc advances.
- HALT: halt=1 and rf_wen=0; start is ignored. Exit only via rst_n.
- rf_wen is asserted only in WB.
- Best-case throughput: 5 cycles per instruction (ready in FETCH, response in the next cycle). With a same-cycle response: 4 cycles.
- start deasserted mid-program has no effect; it is sampled in IDLE only.

Optional Feature:
NPC_FETCH_TIMEOUT_EN
- Defined: a 16-bit counter clears on entry to FETCH and increments each cycle spent in FETCH or WAIT. When it reaches TIMEOUT_CYCLES, go to HALT with err=1 and halt=1, both sticky until reset. retired is unchanged.
- Undefined: no counter, err tied 0, FETCH/WAIT may wait indefinitely.

Test Plan:
- Reset then start=1, ready=1 always, rsp 1 cycle after request, inst=32'h00500093 (addi x1,x0,5) with dec_reg_wen=1 -> rf_wen pulses exactly once in cycle 5, pc 80000000->80000004, retired=1.
- Three addi then 32'h00100073 with dec_isbreak=1 -> halt=1 after 4th DECODE, retired=4, pc=8000000C; further start pulses leave state=6.
- Hold imem_req_ready=0 for 7 cycles -> imem_req_valid stays 1 and imem_addr stays stable; no state change until ready.
- Same-cycle ready and rsp_valid in FETCH -> WAIT skipped, 4-cycle instruction, inst latched correctly.
- Assert rst_n=0 during WAIT, then deliver rsp_valid after release -> outputs at reset values, response ignored, state=IDLE.
- NPC_FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=8 and rsp never returned -> err=1 and halt=1 eight cycles after FETCH entry; retired unchanged.

Source files
------------

// File: rtl/npc_exec_ctrl.sv
// npc_exec_ctrl: multi-cycle fetch/decode/exec/writeback sequencer for the NPC core.
// Fetches over a valid/ready instruction port, latches the instruction for the
// external decoder, gates the register-file write strobe, advances the PC,
// counts retired instructions and halts (sticky) on ebreak.
// Optional fetch watchdog: define NPC_FETCH_TIMEOUT_EN.
`timescale 1ns/1ps

module npc_exec_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h80000000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst,
    input  logic        dec_isbreak,
    input  logic        dec_reg_wen,
    output logic        rf_wen,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic [2:0]  state,
    output logic        halt,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    state_t st;

`ifdef NPC_FETCH_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;
    logic        err_q;
    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign err = 1'b0;
`endif

    // Request and write strobe are pure decodes of the registered state.
    always_comb begin
        imem_req_valid = (st == ST_FETCH);
        rf_wen         = (st == ST_WB) && dec_reg_wen;
    end

    assign imem_addr = pc;
    assign state     = st;

    // Main sequencer: state, PC, instruction latch, retire count, sticky halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= ST_IDLE;
            pc      <= RESET_PC;
            inst    <= '0;
            retired <= '0;
            halt    <= 1'b0;
`ifdef NPC_FETCH_TIMEOUT_EN
            tmo_cnt <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        st <= ST_FETCH;
`ifdef NPC_FETCH_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                ST_FETCH: begin
                    if (imem_req_ready && imem_rsp_valid) begin
                        inst <= imem_rsp_data;
                        st   <= ST_DECODE;
                    end else begin
                        if (imem_req_ready) begin
                            st <= ST_WAIT;
                        end
`ifdef NPC_FETCH_TIMEOUT_EN
                        // Watchdog overrides the FETCH->WAIT move when it expires.
                        if (tmo_cnt == TMO_LAST) begin
                            st    <= ST_HALT;
                            halt  <= 1'b1;
                            err_q <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
`endif
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        inst <= imem_rsp_data;
                        st   <= ST_DECODE;
                    end else begin
`ifdef NPC_FETCH_TIMEOUT_EN
                        if (tmo_cnt == TMO_LAST) begin
                            st    <= ST_HALT;
                            halt  <= 1'b1;
                            err_q <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
`endif
                    end
                end
                ST_DECODE: begin
                    if (dec_isbreak) begin
                        retired <= retired + 32'd1;
                        halt    <= 1'b1;
                        st      <= ST_HALT;
                    end else begin
                        st <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    st <= ST_WB;
                end
                ST_WB: begin
                    pc      <= pc + 32'd4;
                    retired <= retired + 32'd1;
                    st      <= ST_FETCH;
`ifdef NPC_FETCH_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                ST_HALT: begin
                    halt <= 1'b1;
                end
                default: begin
                    st   <= ST_HALT;
                    halt <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npc_exec_ctrl.sv
// Self-checking bench for npc_exec_ctrl: memory/decoder stub driven per cycle,
// expected writebacks queued when responses are driven, compared at WB.
`timescale 1ns/1ps

module tb_npc_exec_ctrl;

    localparam logic [31:0] RPC    = 32'h80000000;
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst;
    logic        dec_isbreak;
    logic        dec_reg_wen;
    logic        rf_wen;
    logic [31:0] pc;
    logic [31:0] retired;
    logic [2:0]  state;
    logic        halt;
    logic        err;

    npc_exec_ctrl #(.RESET_PC(RPC), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst(inst),
        .dec_isbreak(dec_isbreak), .dec_reg_wen(dec_reg_wen),
        .rf_wen(rf_wen), .pc(pc), .retired(retired), .state(state),
        .halt(halt), .err(err)
    );

    always #5 clk = ~clk;

    // Decoder stub: ebreak, and OP-IMM with nonzero rd writes the register file.
    function automatic logic wen_of(input logic [31:0] d);
        return (d[6:0] == 7'h13) && (d[11:7] != 5'd0);
    endfunction
    assign dec_isbreak = (inst == EBREAK);
    assign dec_reg_wen = wen_of(inst);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] i;
        logic        w;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        obs_q[$];
    logic [31:0] mem [0:3];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          last_wen_cyc = 0;
    int          wen_pulses = 0;
    int          stall_cnt = 0;
    int          rsp_mode = 0;   // 0: next cycle, 1: same cycle, 2: never
    logic [31:0] req_addr = '0;

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        logic [31:0] off;
        off = a - RPC;
        if (off < 32'd16) return mem[off[3:2]];
        return 32'h00000013;
    endfunction

    task automatic give(input logic [31:0] a);
        logic [31:0] d;
        d = mem_at(a);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        if (d != EBREAK) exp_q.push_back('{a: a, i: d, w: wen_of(d)});
    endtask

    // One clock: observe at negedge, then drive memory-side inputs.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (state == 3'd5) obs_q.push_back('{a: pc, i: inst, w: rf_wen});
        if (rf_wen) begin
            wen_pulses++;
            last_wen_cyc = cyc;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_req_ready = 1'b1;
        if (state == 3'd1) begin
            if (stall_cnt > 0) begin
                imem_req_ready = 1'b0;
                stall_cnt--;
            end else begin
                req_addr = imem_addr;
                if (rsp_mode == 1) give(req_addr);
            end
        end else if (state == 3'd2 && rsp_mode == 0) begin
            give(req_addr);
        end
    endtask

    task automatic wait_obs(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            cycle();
            if (obs_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            cycle();
            if (state == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        exp_q.delete();
        obs_q.delete();
        stall_cnt = 0;
        wen_pulses = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic kick();
        cycle();
        start = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 3'd0) $display("FAIL reset_state got %0d want 0", state); else passes++;
        checks++; if (pc !== RPC) $display("FAIL reset_pc got %h want %h", pc, RPC); else passes++;
        checks++; if (inst !== 32'd0) $display("FAIL reset_inst got %h want 0", inst); else passes++;
        checks++; if (retired !== 32'd0) $display("FAIL reset_retired got %0d want 0", retired); else passes++;
        checks++;
        if ({imem_req_valid, rf_wen, halt, err} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000", {imem_req_valid, rf_wen, halt, err});
        else passes++;
    endtask

    task automatic test_single_addi();
        bit ok;
        txn_t o, e;
        rsp_mode = 0;
        kick();
        wait_obs(20, ok);
        checks++; if (!ok) $display("FAIL addi_wb_timeout got none want WB"); else passes++;
        checks++;
        if (last_wen_cyc - start_cyc !== 5)
            $display("FAIL addi_wen_cycle got %0d want 5", last_wen_cyc - start_cyc);
        else passes++;
        start = 1'b0;
        cycle();
        checks++; if (pc !== 32'h80000004) $display("FAIL addi_pc got %h want 80000004", pc); else passes++;
        checks++; if (retired !== 32'd1) $display("FAIL addi_retired got %0d want 1", retired); else passes++;
        checks++; if (wen_pulses !== 1) $display("FAIL addi_pulses got %0d want 1", wen_pulses); else passes++;
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (o !== e) $display("FAIL addi_txn got %h want %h", o, e); else passes++;
            checks++; if (e.i !== 32'h00500093) $display("FAIL addi_fetch got %h want 00500093", e.i); else passes++;
        end
    endtask

    task automatic test_ebreak();
        bit ok;
        txn_t o, e;
        wait_state(3'd6, 80, ok);
        checks++; if (!ok) $display("FAIL ebreak_halt_timeout got %0d want 6", state); else passes++;
        checks++; if (halt !== 1'b1) $display("FAIL ebreak_halt got %b want 1", halt); else passes++;
        checks++; if (retired !== 32'd4) $display("FAIL ebreak_retired got %0d want 4", retired); else passes++;
        checks++; if (pc !== 32'h8000000C) $display("FAIL ebreak_pc got %h want 8000000C", pc); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL ebreak_err got %b want 0", err); else passes++;
        checks++;
        if (obs_q.size() !== 2 || exp_q.size() !== 2)
            $display("FAIL ebreak_wb_count got %0d/%0d want 2/2", obs_q.size(), exp_q.size());
        else passes++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (o !== e) $display("FAIL ebreak_txn got %h want %h", o, e); else passes++;
        end
        for (int i = 0; i < 6; i++) begin
            start = i[0];
            cycle();
        end
        start = 1'b0;
        checks++; if (state !== 3'd6) $display("FAIL halt_sticky got %0d want 6", state); else passes++;
        checks++; if (wen_pulses !== 2) $display("FAIL total_pulses got %0d want 2", wen_pulses); else passes++;
    endtask

    task automatic test_stall();
        bit ok;
        txn_t o, e;
        do_reset();
        rsp_mode = 0;
        stall_cnt = 7;
        kick();
        for (int i = 0; i < 7; i++) begin
            cycle();
            checks++; if (state !== 3'd1) $display("FAIL stall_state got %0d want 1", state); else passes++;
            checks++; if (imem_req_valid !== 1'b1) $display("FAIL stall_valid got %b want 1", imem_req_valid); else passes++;
            checks++; if (imem_addr !== RPC) $display("FAIL stall_addr got %h want %h", imem_addr, RPC); else passes++;
        end
        start = 1'b0;
        cycle();
        checks++; if (state !== 3'd1) $display("FAIL stall_last got %0d want 1", state); else passes++;
        cycle();
        checks++; if (state !== 3'd2) $display("FAIL stall_wait got %0d want 2", state); else passes++;
        wait_obs(10, ok);
        checks++; if (!ok) $display("FAIL stall_wb_timeout got none want WB"); else passes++;
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (o !== e) $display("FAIL stall_txn got %h want %h", o, e); else passes++;
        end
    endtask

    task automatic test_same_cycle();
        bit ok;
        txn_t o, e;
        do_reset();
        rsp_mode = 1;
        kick();
        cycle();
        start = 1'b0;
        checks++; if (state !== 3'd1) $display("FAIL same_fetch got %0d want 1", state); else passes++;
        cycle();
        checks++; if (state !== 3'd3) $display("FAIL same_skip_wait got %0d want 3", state); else passes++;
        checks++; if (inst !== 32'h00500093) $display("FAIL same_inst got %h want 00500093", inst); else passes++;
        wait_obs(10, ok);
        checks++;
        if (!ok || last_wen_cyc - start_cyc !== 4)
            $display("FAIL same_wen_cycle got %0d want 4", last_wen_cyc - start_cyc);
        else passes++;
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (o !== e) $display("FAIL same_txn got %h want %h", o, e); else passes++;
        end
        wait_state(3'd6, 40, ok);
        checks++; if (retired !== 32'd4) $display("FAIL same_retired got %0d want 4", retired); else passes++;
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        do_reset();
        rsp_mode = 0;
        kick();
        wait_obs(20, ok);
        start = 1'b0;
        rsp_mode = 2;
        wait_state(3'd2, 10, ok);
        checks++; if (!ok || retired !== 32'd1) $display("FAIL rstwait_setup got %0d/%0d want 2/1", state, retired); else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, imem_req_valid, halt} !== 5'b00000 || pc !== RPC || inst !== 32'd0 || retired !== 32'd0)
            $display("FAIL rstwait_values got st=%0d pc=%h inst=%h ret=%0d want 0/%h/0/0", state, pc, inst, retired, RPC);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEADBEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checks++; if (state !== 3'd0) $display("FAIL rstwait_state got %0d want 0", state); else passes++;
        checks++; if (inst !== 32'd0) $display("FAIL rstwait_inst got %h want 0", inst); else passes++;
    endtask

`ifdef NPC_FETCH_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        rsp_mode = 2;
        kick();
        while (cyc - start_cyc < 8) cycle();
        start = 1'b0;
        checks++; if ({err, halt} !== 2'b00) $display("FAIL tmo_early got %b want 00", {err, halt}); else passes++;
        cycle();
        checks++; if ({err, halt} !== 2'b11) $display("FAIL tmo_flags got %b want 11", {err, halt}); else passes++;
        checks++; if (state !== 3'd6) $display("FAIL tmo_state got %0d want 6", state); else passes++;
        checks++; if (retired !== 32'd0) $display("FAIL tmo_retired got %0d want 0", retired); else passes++;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem[0] = 32'h00500093;   // addi x1,x0,5
        mem[1] = 32'h00A00113;   // addi x2,x0,10
        mem[2] = 32'h00000013;   // nop: no register write
        mem[3] = EBREAK;
        test_reset();
        test_single_addi();
        test_ebreak();
        test_stall();
        test_same_cycle();
        test_reset_in_wait();
`ifdef NPC_FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
